// File: rtl/inverter_pipe_if.sv
// Streaming bus (valid/ready/data) used on both sides of inverter_pipe.
// A beat transfers on every rising clock edge where valid and ready are both high.
interface inverter_pipe_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/inverter_pipe.sv
// Pipelined WIDTH-bit inverter with run-time selectable transform, STAGES
// register stages behind valid/ready handshakes, and an output beat counter.
module inverter_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNTW   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic [WIDTH-1:0]   cfg_mask_i,
    inverter_pipe_if.slave     in_i,
    inverter_pipe_if.master    out_o,
    output logic [CNTW-1:0]    beat_cnt_o
);
    // Handshake: a beat moves when valid && ready at a rising edge; valid, once
    // raised by a producer, holds with stable data until ready is seen.
    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_INV  = 2'b01;
    localparam logic [1:0] MODE_MASK = 2'b10;
    localparam logic [1:0] MODE_ALT  = 2'b11;

    logic [1:0]        mode_q, mode_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic              phase_q, phase_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]  dat_q [STAGES];
    logic [WIDTH-1:0]  dat_d [STAGES];
    logic [STAGES-1:0] load;
    logic              accept;
    logic [WIDTH-1:0]  xform;

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin : ready_chain
        logic c;
        c = out_o.ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            c       = ~vld_q[k] | c;
            load[k] = c;
        end
    end

    assign in_i.ready = load[0];
    assign accept     = in_i.valid & load[0];

    always_comb begin
        xform = in_i.data;
        case (mode_q)
            MODE_PASS: xform = in_i.data;
            MODE_INV:  xform = ~in_i.data;
            MODE_MASK: xform = in_i.data ^ mask_q;
            MODE_ALT:  xform = phase_q ? ~in_i.data : in_i.data;
            default:   xform = in_i.data;
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        mask_d  = mask_q;
        phase_d = phase_q;
        if (accept && mode_q == MODE_ALT) phase_d = ~phase_q;
        if (cfg_we_i) begin
            mode_d = cfg_mode_i;
            mask_d = cfg_mask_i;
            if (cfg_mode_i == MODE_ALT) phase_d = 1'b0;
        end
    end

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load[0]) begin
            vld_d[0] = in_i.valid;
            if (in_i.valid) dat_d[0] = xform;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) dat_d[k] = dat_q[k-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_o.valid && out_o.ready) cnt_d = cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_PASS;
            mask_q  <= '0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= '0;
            dat_q   <= '{default: '0};
        end else begin
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
        end
    end

    assign out_o.valid = vld_q[STAGES-1];
    assign out_o.data  = dat_q[STAGES-1];
    assign beat_cnt_o  = cnt_q;
endmodule
